// File: rtl/mem_stage_lsu_if.sv
// MEM-stage request port and data-memory port of the load/store unit.
// The slave modport is the LSU side; the master is the pipeline/memory side.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       load_data;
  logic              misalign;
  logic              sb_empty;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output stall, load_data, misalign, sb_empty, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  stall, load_data, misalign, sb_empty, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: in-order store queue drained with read-modify-write, zero-latency loads.
// Define STORE_FWD_EN to serve fully covered loads straight from the youngest queued store.
module mem_stage_lsu #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_stage_lsu_if.slave   bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_W - 2;

  typedef enum logic [1:0] {DR_IDLE, DR_READ, DR_WRITE} dr_state_t;

  logic [WA-1:0] r_q_addr [SB_DEPTH];
  logic [31:0]   r_q_data [SB_DEPTH];
  logic [3:0]    r_q_mask [SB_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hold;
  dr_state_t     r_state, w_next;

  logic [WA-1:0] w_word;
  logic [1:0]    w_a;
  logic [3:0]    w_req_mask;
  logic [31:0]   w_req_data;
  logic          w_misalign, w_ok, w_full, w_ld, w_ld_port, w_ld_fwd, w_push, w_pop;
  logic          w_hit, w_fwd;
  logic [PW-1:0] w_idx;
  logic [3:0]    w_fwd_mask;
  logic [31:0]   w_fwd_data, w_src, w_merge;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_word = bus.req_addr[ADDR_W-1:2];
  assign w_a    = bus.req_addr[1:0];

  always_comb begin
    w_misalign = 1'b0;
    w_req_mask = 4'b1111;
    w_req_data = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_req_mask = 4'b0001 << w_a;
        w_req_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = w_a[0];
        w_req_mask = w_a[1] ? 4'b1100 : 4'b0011;
        w_req_data = {2{bus.req_wdata[15:0]}};
      end
      default: w_misalign = (w_a != 2'b00);
    endcase
    w_misalign = w_misalign & bus.req_valid;
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_mask = '0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (CW'(k) < r_count && r_q_addr[w_idx] == w_word) begin
        w_hit      = 1'b1;
        w_fwd_mask = r_q_mask[w_idx];
        w_fwd_data = r_q_data[w_idx];
      end
    end
  end

`ifdef STORE_FWD_EN
  assign w_fwd = w_hit && ((w_fwd_mask & w_req_mask) == w_req_mask);
`else
  assign w_fwd = 1'b0;
`endif

  assign w_ok      = bus.req_valid & ~w_misalign;
  assign w_full    = (r_count == CW'(SB_DEPTH));
  assign w_ld      = w_ok & ~bus.req_we;
  assign w_ld_fwd  = w_ld & w_fwd;
  assign w_ld_port = w_ld & ~w_hit & (r_state == DR_IDLE) & ~w_full;
  assign w_push    = w_ok & bus.req_we & ~w_full;
  assign w_pop     = (r_state == DR_WRITE);

  assign bus.stall    = w_ok & ~(w_ld_port | w_ld_fwd | w_push);
  assign bus.misalign = w_misalign;
  assign bus.sb_empty = (r_count == '0) && (r_state == DR_IDLE);

  assign w_src  = w_ld_fwd ? w_fwd_data : bus.mem_rdata;
  assign w_byte = w_src[{w_a, 3'b000} +: 8];
  assign w_half = w_src[{w_a[1], 4'b0000} +: 16];

  always_comb begin
    bus.load_data = '0;
    if (w_ld_port | w_ld_fwd) begin
      case (bus.req_size)
        2'b00:   bus.load_data = {{24{~bus.req_unsigned & w_byte[7]}}, w_byte};
        2'b01:   bus.load_data = {{16{~bus.req_unsigned & w_half[15]}}, w_half};
        default: bus.load_data = w_src;
      endcase
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++)
      w_merge[8*b +: 8] = r_q_mask[r_head][b] ? r_q_data[r_head][8*b +: 8]
                                             : bus.mem_rdata[8*b +: 8];
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DR_IDLE;
    else        r_state <= w_next;
  end

  // Drain FSM: next state; an accepted port load blocks the drain start
  always_comb begin
    w_next = r_state;
    case (r_state)
      DR_IDLE:  if (r_count != '0 && !w_ld_port)
                  w_next = (r_q_mask[r_head] == 4'b1111) ? DR_WRITE : DR_READ;
      DR_READ:  w_next = DR_WRITE;
      DR_WRITE: w_next = DR_IDLE;
      default:  w_next = DR_IDLE;
    endcase
  end

  // Drain FSM: memory port outputs
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      DR_READ: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {r_q_addr[r_head], 2'b00};
      end
      DR_WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {r_q_addr[r_head], 2'b00};
        bus.mem_wdata = (r_q_mask[r_head] == 4'b1111) ? r_q_data[r_head] : r_hold;
      end
      default: if (w_ld_port) begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {w_word, 2'b00};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (r_state == DR_READ) r_hold <= w_merge;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= w_word;
      r_q_data[r_tail] <= w_req_data;
      r_q_mask[r_tail] <= w_req_mask;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a word-addressed memory model.
module tb_mem_stage_lsu;
  localparam int SB_DEPTH = 4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(32)) bus();
  mem_stage_lsu #(.SB_DEPTH(SB_DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h11223344;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = d;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Hold a request until accepted; report stall cycles and the accept-cycle outputs.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] d, output int stalls, output logic [31:0] ld,
                       output logic rd);
    drive(1'b1, we, sz, uns, a, d);
    #1;
    stalls = 0;
    while (bus.stall && stalls < 50) begin
      cyc(); #1;
      stalls++;
    end
    if (bus.stall) chk("accept_timeout", 32'd1, 32'd0);
    ld = bus.load_data;
    rd = bus.mem_read;
    cyc();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    while (!bus.sb_empty && n < 100) begin
      cyc(); n++;
    end
    if (!bus.sb_empty) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int st, tot;
    logic [31:0] ld;
    logic rd;

    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    chk("rst_stall",     32'(bus.stall), 32'd0);
    chk("rst_misalign",  32'(bus.misalign), 32'd0);
    chk("rst_load_data", bus.load_data, 32'h0);
    chk("rst_sb_empty",  32'(bus.sb_empty), 32'd1);
    chk("rst_mem_read",  32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    cyc();

    // SW then LW to the same word
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, st, ld, rd);
    chk("sw_accept_stalls", st, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, st, ld, rd);
    chk("lw_after_sw_data", ld, 32'hDEADBEEF);
    chk("lw_after_sw_stalls", st, FWD ? 0 : 2);
    chk("lw_after_sw_rd", 32'(rd), FWD ? 32'd0 : 32'd1);
    wait_empty();
    chk("sw_committed", mem[4], 32'hDEADBEEF);

    // SB into a preloaded word: read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h80, st, ld, rd);
    chk("sb_accept_stalls", st, 0);
    cyc();
    chk("rmw_read", 32'(bus.mem_read), 32'd1);
    chk("rmw_read_addr", bus.mem_addr, 32'h20);
    chk("rmw_read_nowr", 32'(bus.mem_write), 32'd0);
    cyc();
    chk("rmw_write", 32'(bus.mem_write), 32'd1);
    chk("rmw_wdata", bus.mem_wdata, 32'h11228044);
    chk("rmw_write_nord", 32'(bus.mem_read), 32'd0);
    cyc();
    chk("rmw_mem", mem[8], 32'h11228044);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, st, ld, rd);
    chk("lb_sext", ld, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, st, ld, rd);
    chk("lbu_zext", ld, 32'h00000080);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, st, ld, rd);
    chk("lh_sext_upper", ld, 32'h00001122);

    // Misaligned half load is dropped
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
    #1;
    chk("mis_flag", 32'(bus.misalign), 32'd1);
    chk("mis_stall", 32'(bus.stall), 32'd0);
    chk("mis_rd", 32'(bus.mem_read), 32'd0);
    chk("mis_ld", bus.load_data, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mis_queue", 32'(bus.sb_empty), 32'd1);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h46, 32'h12345678);
    #1;
    chk("mis_sw_flag", 32'(bus.misalign), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mis_sw_queue", 32'(bus.sb_empty), 32'd1);

    // Back-to-back stores overflow the queue; last one rewrites word 0x40
    tot = 0;
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i), st, ld, rd);
      tot += st;
    end
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, st, ld, rd);
    tot += st;
    chk("sq_full_stalled", 32'(tot != 0), 32'd1);
    wait_empty();
    chk("order_w40", mem[16], 32'hCAFEF00D);
    for (int i = 1; i < 7; i++) chk("order_wN", mem[16 + i], 32'hA0000000 + 32'(i));

    // SH then LHU / LW on the same word
    issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, st, ld, rd);
    issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, st, ld, rd);
    chk("lhu_data", ld, 32'h0000BEEF);
    chk("lhu_nostall", 32'(st == 0), FWD ? 32'd1 : 32'd0);
    chk("lhu_rd", 32'(rd), FWD ? 32'd0 : 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, st, ld, rd);
    chk("lw_partial_data", ld, 32'hBEEF0000);
    chk("lw_partial_stall", 32'(st != 0), FWD ? 32'd1 : 32'd0);
    wait_empty();

    // Reset in the middle of a read-modify-write
    issue(1'b1, 2'b00, 1'b0, 32'h61, 32'h55, st, ld, rd);
    cyc();
    chk("rstmid_in_read", 32'(bus.mem_read), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("rstmid_wr", 32'(bus.mem_write), 32'd0);
    chk("rstmid_empty", 32'(bus.sb_empty), 32'd1);
    chk("rstmid_stall", 32'(bus.stall), 32'd0);
    chk("rstmid_ld", bus.load_data, 32'h0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("rstmid_mem", mem[24], 32'h0);
    chk("rstmid_empty2", 32'(bus.sb_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
